rtc_bus_ctrl: RTL and testbench
===============================

# rtc_bus_ctrl

Bus-cycle generator for the external real-time-clock chip's multiplexed address/data port. It sits between the time-keeping/edit logic, which issues single-byte read and write requests, and the chip pins AD, CS, RD, RW and the bidirectional Dato_sal bus. Each request becomes one fully timed Intel-style multiplexed bus cycle, with programmable phase widths. Read data is returned and a completion pulse is raised.

## Interface
Parameters:
- T_PH, 10, width of each bus phase in clk cycles (≥1; 10 = 100 ns at 100 MHz)
- T_REC, 10, recovery time in clk cycles with CS high before the next cycle (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_wr  in  1  write request, sampled in IDLE only
- req_rd  in  1  read request, sampled in IDLE only
- addr  in  8  register address, latched at request acceptance
- wdata  in  8  write data, latched at request acceptance
- busy  out  1  high while a cycle is in progress
- done  out  1  one-cycle pulse when a cycle completes
- rdata  out  8  last read byte, held until the next read completes
- AD  out  1  address strobe, active low
- CS  out  1  chip select, active low
- RD  out  1  read strobe, active low
- RW  out  1  write strobe, active low
- Dato_sal  inout  8  multiplexed address/data bus, tri-stated when not driven

## Operation
- All of AD, CS, RD, RW, the bus output-enable, the bus output value, busy, done and rdata are registered. No combinational paths from inputs to pins.
- FSM states and their outputs:
  - IDLE: CS=AD=RD=RW=1, bus Z, busy=0.
  - S_ADDR (T_PH cycles): CS=0, AD=0, bus drives latched addr.
  - S_TURN (T_PH cycles): CS=0, AD=1. Write drives wdata; read leaves the bus Z.
  - S_STRB (T_PH cycles): CS=0, AD=1, RW=0 (write) or RD=0 (read). Write keeps driving wdata.
  - S_HOLD (T_PH cycles): CS=0, RD=RW=1. Write keeps driving wdata; read leaves the bus Z.
  - S_REC (T_REC cycles): CS=1, all strobes 1, bus Z.
  - S_REC returns to IDLE.
- Acceptance: in IDLE, if req_wr or req_rd is high at a clk edge, latch addr, wdata and the direction, and enter S_ADDR.
- req_wr and req_rd both high: a write is performed and the read is dropped. Only one done is produced.
- Requests while busy=1 are ignored, not queued.
- Read capture: rdata ← Dato_sal at the clk edge that ends S_STRB, i.e. while RD is still low. rdata is unchanged by writes.
- done=1 for exactly the first IDLE cycle after S_REC, for both reads and writes.
- A phase counter (8 bits) reloads on every state entry. States advance when the counter reaches the phase width minus 1.

## Timing
- Reset values: CS=AD=RD=RW=1, Dato_sal Z, busy=0, done=0, rdata=8'h00, state IDLE.
- Reset asserted mid-cycle forces the reset values asynchronously. The aborted transfer produces no done and leaves rdata unchanged from its reset value.
- Request accepted at edge k:
  - busy=1 and S_ADDR outputs appear after edge k.
  - Total cycle length is 4·T_PH+T_REC clocks.
  - busy falls and done pulses in the cycle after edge k+4·T_PH+T_REC.
- The done cycle is IDLE: a request present in that cycle is accepted, giving back-to-back cycles separated only by the T_REC recovery.
- The bus is never driven during S_REC or IDLE. This guarantees at least T_REC cycles of turnaround before the chip can be addressed again.
- AD rises while CS is low and before any RD/RW edge (S_TURN separation ≥ T_PH). RD/RW rise T_PH cycles before CS does.

## Test plan
- Write, T_PH=2, T_REC=2, addr=0x21, wdata=0x45 at edge 0 → AD low for edges 1–2 with bus 0x21; bus 0x45 in cycles 3–8; RW low in cycles 5–6; CS high in cycles 9–10; done=1 and busy=0 in cycle 11; RD never low.
- Read, addr=0x23, chip model drives 0x37 while RD is low → bus Z after S_ADDR; rdata=0x37 in the done cycle; RW never low.
- req_wr=req_rd=1 in IDLE → exactly one write cycle, RD never low, one done pulse.
- req_rd pulsed during S_STRB of a write → ignored; a single done; the following state is IDLE.
- reset raised during S_STRB of a read → CS/RD/AD/RW=1 and bus Z immediately; no done; rdata=0x00.
- Second request held high in the done cycle → accepted; its AD falls in the very next cycle.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// Multiplexed address/data bus-cycle generator for the external RTC chip.
// One request becomes one fully timed ADDR/TURN/STRB/HOLD/REC cycle; every pin is registered.
module rtc_bus_ctrl #(
  parameter int T_PH  = 10,
  parameter int T_REC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       RW,
  inout  wire  [7:0] Dato_sal
);

  typedef enum logic [2:0] {IDLE, S_ADDR, S_TURN, S_STRB, S_HOLD, S_REC} state_t;

  localparam logic [7:0] PH_LAST  = 8'(T_PH - 1);
  localparam logic [7:0] REC_LAST = 8'(T_REC - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       is_wr, is_wr_nxt;
  logic       accept, last;
  logic [7:0] wdata_q, dout;
  logic       oe;
  logic       cs_nxt, ad_nxt, rd_nxt, rw_nxt, oe_nxt;

  always_comb begin
    last      = (state == S_REC) ? (cnt == REC_LAST) : (cnt == PH_LAST);
    state_nxt = state;
    is_wr_nxt = is_wr;
    accept    = 1'b0;
    case (state)
      IDLE: if (req_wr || req_rd) begin
        state_nxt = S_ADDR;
        is_wr_nxt = req_wr;   // write wins when both are requested
        accept    = 1'b1;
      end
      S_ADDR:  if (last) state_nxt = S_TURN;
      S_TURN:  if (last) state_nxt = S_STRB;
      S_STRB:  if (last) state_nxt = S_HOLD;
      S_HOLD:  if (last) state_nxt = S_REC;
      S_REC:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    cs_nxt = 1'b1;
    ad_nxt = 1'b1;
    rd_nxt = 1'b1;
    rw_nxt = 1'b1;
    oe_nxt = 1'b0;
    case (state_nxt)
      S_ADDR: begin
        cs_nxt = 1'b0;
        ad_nxt = 1'b0;
        oe_nxt = 1'b1;
      end
      S_TURN, S_HOLD: begin
        cs_nxt = 1'b0;
        oe_nxt = is_wr_nxt;
      end
      S_STRB: begin
        cs_nxt = 1'b0;
        oe_nxt = is_wr_nxt;
        rw_nxt = ~is_wr_nxt;
        rd_nxt = is_wr_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      is_wr   <= 1'b0;
      wdata_q <= 8'd0;
      dout    <= 8'd0;
      oe      <= 1'b0;
      CS      <= 1'b1;
      AD      <= 1'b1;
      RD      <= 1'b1;
      RW      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
      is_wr <= is_wr_nxt;
      if (accept) begin
        wdata_q <= wdata;
        dout    <= addr;
      end else if (state == S_ADDR && last) begin
        dout <= wdata_q;
      end
      oe   <= oe_nxt;
      CS   <= cs_nxt;
      AD   <= ad_nxt;
      RD   <= rd_nxt;
      RW   <= rw_nxt;
      busy <= (state_nxt != IDLE);
      done <= (state == S_REC) && last;
      // Sample while RD is still low, on the edge that closes the strobe phase.
      if (state == S_STRB && last && !is_wr)
        rdata <= Dato_sal;
    end
  end

  assign Dato_sal = oe ? dout : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl with T_PH=2, T_REC=2 and a simple RTC chip model.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_wr = 1'b0, req_rd = 1'b0;
  logic [7:0] addr = 8'd0, wdata = 8'd0;
  logic       busy, done;
  logic [7:0] rdata;
  logic       AD, CS, RD, RW;
  wire  [7:0] Dato_sal;
  logic [7:0] chip_data = 8'h37;
  logic [7:0] exp_rdata = 8'h00;

  int nvec = 0;
  int nerr = 0;

  rtc_bus_ctrl #(.T_PH(2), .T_REC(2)) dut (
    .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .AD(AD), .CS(CS), .RD(RD), .RW(RW), .Dato_sal(Dato_sal)
  );

  // Chip drives its register contents only while selected and read-strobed.
  assign Dato_sal = (!CS && !RD) ? chip_data : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {busy,done,CS,AD,RD,RW}
  function automatic logic [5:0] pins();
    return {busy, done, CS, AD, RD, RW};
  endfunction

  // One full transfer; called at a negedge with the bus IDLE (or in the done cycle).
  // Cycle c is the clock period after edge c-1, edge 0 being the accepting edge.
  task automatic xfer(input bit we, input bit re, input logic [7:0] a, input logic [7:0] d,
                      input int pulse_c);
    bit wr_eff;
    logic [5:0] e;
    wr_eff = we;
    req_wr = we; req_rd = re; addr = a; wdata = d;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      e = {c >= 1 && c <= 10, c == 11, !(c <= 8), !(c <= 2),
           !(!wr_eff && (c == 5 || c == 6)), !(wr_eff && (c == 5 || c == 6))};
      chk($sformatf("pins c%0d", c), {26'd0, pins()}, {26'd0, e});
      if (c <= 2)
        chk($sformatf("bus addr c%0d", c), {24'd0, Dato_sal}, {24'd0, a});
      else if (wr_eff && c <= 8)
        chk($sformatf("bus wdata c%0d", c), {24'd0, Dato_sal}, {24'd0, d});
      else if (!wr_eff && (c == 5 || c == 6))
        chk($sformatf("bus chip c%0d", c), {24'd0, Dato_sal}, {24'd0, chip_data});
      if (c == 11) begin
        if (!wr_eff) exp_rdata = chip_data;
        chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
      end
      if (c == 1) begin req_wr = 1'b0; req_rd = 1'b0; end
      if (pulse_c != 0 && c == pulse_c) req_rd = 1'b1;
      if (pulse_c != 0 && c == pulse_c + 1) req_rd = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, {26'd0, pins()}, {26'd0, 6'b001111});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset pins", {26'd0, pins()}, {26'd0, 6'b001111});
    chk("reset rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
    idle_chk("idle after reset");

    // Plain write, then a read back-to-back in the done cycle.
    xfer(1'b1, 1'b0, 8'h21, 8'h45, 0);
    chip_data = 8'h37;
    xfer(1'b0, 1'b1, 8'h23, 8'h00, 0);
    idle_chk("idle after read");

    // Both requests: write only, single done, rdata untouched.
    xfer(1'b1, 1'b1, 8'h30, 8'h99, 0);
    idle_chk("idle after both");

    // Read request pulsed during the write strobe phase is dropped.
    xfer(1'b1, 1'b0, 8'h0F, 8'hC3, 5);
    idle_chk("idle after pulse 1");
    idle_chk("idle after pulse 2");

    // Reset in the middle of a read strobe.
    chip_data = 8'h6C;
    req_rd = 1'b1; addr = 8'h55;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req_rd = 1'b0;
    end
    chk("rd low before reset", {31'd0, RD}, 32'd0);
    reset = 1'b1;
    #1;
    chk("abort pins", {26'd0, pins()}, {26'd0, 6'b001111});
    chk("abort rdata", {24'd0, rdata}, 32'd0);
    exp_rdata = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("post abort c%0d", c), {18'd0, rdata, pins()}, {18'd0, 8'h00, 6'b001111});
    end

    // Transfer still works after the abort.
    chip_data = 8'hA9;
    xfer(1'b0, 1'b1, 8'h7E, 8'h00, 0);
    idle_chk("idle final");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
